mesh_route_pipe: RTL and testbench
==================================

# mesh_route_pipe

Registered, flit-level route-compute stage for a 2-D mesh router node, parametrised in coordinate width, mesh size, node position and buffer depth. It accepts head/body/tail flits over a valid/ready handshake, buffers them in an input FIFO, and computes a one-hot output port from each head flit's destination using dimension-ordered XY routing. It locks that port for the rest of the packet and presents registered flits to the switch allocator.

## Interface
- COORD_W, 30: width of each destination coordinate, unsigned.
- DATA_W, 64: payload width per flit.
- MESH_X, 8: mesh columns; valid x is 0..MESH_X-1.
- MESH_Y, 8: mesh rows; valid y is 0..MESH_Y-1.
- CUR_X, 0: this node's x coordinate.
- CUR_Y, 0: this node's y coordinate.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  FIFO can accept a flit.
- in_head  in  1  flit is a packet head.
- in_tail  in  1  flit is a packet tail; head+tail together form a single-flit packet.
- dest_x  in  COORD_W  destination x; sampled only on head flits.
- dest_y  in  COORD_W  destination y; sampled only on head flits.
- in_data  in  DATA_W  payload.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts.
- out_head, out_tail  out  1 each  flags forwarded from the input flit.
- out_data  out  DATA_W  payload.
- outport  out  5  one-hot port: [0] local, [1] east (+x), [2] west (−x), [3] north (+y), [4] south (−y).
- route_err  out  1  one-cycle pulse; present only with ROUTE_ERR_EN.

## Operation
- **Input FIFO:**
  - Push on in_valid && in_ready.
  - in_ready = !full; there is no push-through when full, even if a pop occurs the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap around.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- **Route function:** unsigned compares against CUR_X/CUR_Y.
  - dest_x > CUR_X → east; dest_x < CUR_X → west.
  - Otherwise dest_y > CUR_Y → north; dest_y < CUR_Y → south.
  - Otherwise local.
  - Exactly one outport bit is set whenever out_valid=1.
- **State machine (route lock):**
  - IDLE: the FIFO head must be a head flit. A non-head flit at the FIFO head in IDLE is popped and discarded, and route_err pulses if it is compiled in.
  - On a head pop, compute the route and store it in lock_port. Go to BODY unless the flit is also a tail, in which case stay in IDLE.
  - BODY: body flits use lock_port. A tail pop returns the machine to IDLE.
  - A head flit arriving while in BODY terminates the current packet: a new route is computed and the machine stays in BODY, or goes to IDLE if that head is also a tail.
- **Output register:**
  - A single stage, loaded from the FIFO whenever it is empty or out_ready=1.
  - out_* holds stable while out_valid && !out_ready.
- **Reset:**
  - out_valid=0, out_head=0, out_tail=0, out_data=0, outport=0, route_err=0.
  - in_ready=1 on the first cycle after reset.
  - FIFO is emptied, state is IDLE, lock_port=0.
  - Reset mid-packet drops all buffered and registered flits.

## Timing
- Latency: a flit accepted at edge N with the FIFO empty and the output stage free appears at out_valid after edge N+1.
- Throughput: one flit per cycle when out_ready=1 continuously.
- Backpressure: the FIFO fills after FIFO_DEPTH+1 accepted flits with out_ready=0, counting the output stage. in_ready falls in the cycle following the fill.
- After out_ready rises, in_ready returns 1 cycle later.
- route_err is asserted during the cycle after the offending pop.

## Configuration
- **ROUTE_ERR_EN defined:**
  - Port route_err exists.
  - A head with dest_x ≥ MESH_X or dest_y ≥ MESH_Y is dropped together with its whole packet (state DROP, exited on tail). route_err pulses once per dropped packet.
  - Orphan body flits in IDLE also pulse route_err.
- **ROUTE_ERR_EN undefined:**
  - No route_err port.
  - Out-of-range destinations are routed by the compare rules unchanged.
  - Orphan flits are discarded silently.

## Test plan
- Reset, CUR=(3,3), single-flit packet to dest (5,1) → out_valid 2 cycles after the push; outport=00010 (east); in_ready=1 throughout.
- 4-flit packet to (3,6), followed by a 1-flit packet to (3,3) → first four outputs outport=01000 (north), fifth outport=00001 (local); flags head, body, body, tail, then head+tail.
- out_ready=0 while 6 flits are pushed, FIFO_DEPTH=4 → 5 flits accepted, in_ready=0; out_data stable; releasing out_ready drains all flits in order.
- Reset asserted after the head of a 3-flit packet → all outputs 0 next cycle; a following body flit is discarded and the next head routes correctly.
- ROUTE_ERR_EN, MESH_X=8, head with dest_x=9 in a 3-flit packet → no out_valid for any of its flits; route_err high for exactly 1 cycle; next packet routes normally.

Source files
------------

// File: rtl/mesh_route_pipe.sv
// XY route-compute stage: input FIFO, per-packet port lock, one registered output stage.
// Latency: 2 cycles from push to out_valid when idle; in_ready = !full, output holds while stalled.
// Build option ROUTE_ERR_EN: out-of-range heads drop their packet and route_err pulses.
module mesh_route_pipe #(
  parameter int COORD_W    = 30,
  parameter int DATA_W     = 64,
  parameter int MESH_X     = 8,
  parameter int MESH_Y     = 8,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_head,
  input  logic               in_tail,
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_head,
  output logic               out_tail,
  output logic [DATA_W-1:0]  out_data,
  output logic [4:0]         outport
`ifdef ROUTE_ERR_EN
  ,
  output logic               route_err
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
  localparam logic [COORD_W-1:0] MX = COORD_W'(MESH_X);
  localparam logic [COORD_W-1:0] MY = COORD_W'(MESH_Y);
`ifdef ROUTE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic               head;
    logic               tail;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  flit_t              mem_q [FIFO_DEPTH];
  logic [PW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               full, empty, push, pop, load, load_en, discard, hd_bad;
  flit_t              hd;
  logic [4:0]         hd_route, flit_port;
  state_t             state_q, state_d;
  logic [4:0]         lock_port_q, lock_port_d;
  logic               out_valid_q, out_valid_d, out_head_q, out_head_d, out_tail_q, out_tail_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [4:0]         outport_q, outport_d;

  function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy);
    if (dx > CX)      return 5'b00010;
    else if (dx < CX) return 5'b00100;
    else if (dy > CY) return 5'b01000;
    else if (dy < CY) return 5'b10000;
    else              return 5'b00001;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign hd       = mem_q[rd_ptr_q[PW-1:0]];
  assign hd_route = xy_route(hd.dx, hd.dy);
  assign hd_bad   = ERR_EN && ((hd.dx >= MX) || (hd.dy >= MY));

  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= {in_head, in_tail, dest_x, dest_y, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      lock_port_q <= '0;
      out_valid_q <= 1'b0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
      out_data_q  <= '0;
      outport_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      out_valid_q <= out_valid_d;
      out_head_q  <= out_head_d;
      out_tail_q  <= out_tail_d;
      out_data_q  <= out_data_d;
      outport_q   <= outport_d;
    end
  end

  // A head always restarts routing, whatever packet was in flight.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      if (hd.head)      state_d = hd.tail ? S_IDLE : (hd_bad ? S_DROP : S_BODY);
      else if (hd.tail) state_d = S_IDLE;
    end
  end

  // Discarded flits never touch the output stage, so they pop even while it is stalled.
  always_comb begin
    discard     = hd.head ? hd_bad : (state_q != S_BODY);
    load_en     = !out_valid_q || out_ready;
    pop         = !empty && (discard || load_en);
    load        = pop && !discard;
    flit_port   = hd.head ? hd_route : lock_port_q;
    lock_port_d = (load && hd.head) ? hd_route : lock_port_q;
    out_valid_d = load_en ? load : out_valid_q;
    out_head_d  = load ? hd.head   : out_head_q;
    out_tail_d  = load ? hd.tail   : out_tail_q;
    out_data_d  = load ? hd.data   : out_data_q;
    outport_d   = load ? flit_port : outport_q;
  end

  assign out_valid = out_valid_q;
  assign out_head  = out_head_q;
  assign out_tail  = out_tail_q;
  assign out_data  = out_data_q;
  assign outport   = outport_q;

`ifdef ROUTE_ERR_EN
  logic route_err_q, route_err_d;

  // One pulse per bad packet: on its head or on an orphan, not on the dropped body.
  always_comb route_err_d = pop && discard && (hd.head || state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) route_err_q <= 1'b0;
    else     route_err_q <= route_err_d;
  end

  assign route_err = route_err_q;
`endif

endmodule

// File: tb/tb_mesh_route_pipe.sv
// Bench for mesh_route_pipe at CUR=(3,3): directed cases, then random traffic against a packet-level model.
module tb_mesh_route_pipe;
  localparam int CW = 30;
  localparam int DW = 64;
`ifdef ROUTE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_head, in_tail;
  logic [CW-1:0] dest_x, dest_y;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, out_ready, out_head, out_tail;
  logic [4:0]    outport;
`ifdef ROUTE_ERR_EN
  logic          route_err;
`endif

  always #5 clk = ~clk;

  mesh_route_pipe #(
    .COORD_W(CW), .DATA_W(DW), .MESH_X(8), .MESH_Y(8),
    .CUR_X(3), .CUR_Y(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head), .in_tail(in_tail),
    .dest_x(dest_x), .dest_y(dest_y), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head), .out_tail(out_tail),
    .out_data(out_data), .outport(outport)
`ifdef ROUTE_ERR_EN
    , .route_err(route_err)
`endif
  );

  typedef struct packed {
    logic          h;
    logic          t;
    logic [DW-1:0] d;
    logic [4:0]    p;
  } exp_t;

  exp_t       q[$];
  int         n_total = 0, n_pass = 0;
  int         exp_err = 0, got_err = 0, n_out = 0;
  bit         m_in_pkt = 0, m_drop = 0;
  logic [4:0] m_port = '0;
  bit         acc = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [4:0] prev_port, last_port = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] xy(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
    if (dx > 3)      return 5'b00010;
    else if (dx < 3) return 5'b00100;
    else if (dy > 3) return 5'b01000;
    else if (dy < 3) return 5'b10000;
    return 5'b00001;
  endfunction

  // Packet-level model: decide every accepted flit's fate at the input, in arrival order.
  task automatic model_push();
    exp_t e;
    if (in_head) begin
      if (ERR && (dest_x >= 8 || dest_y >= 8)) begin
        exp_err++;
        m_drop   = !in_tail;
        m_in_pkt = 0;
      end else begin
        m_port   = xy(dest_x, dest_y);
        e        = '{h: 1'b1, t: in_tail, d: in_data, p: m_port};
        q.push_back(e);
        m_in_pkt = !in_tail;
        m_drop   = 0;
      end
    end else if (m_drop) begin
      if (in_tail) m_drop = 0;
    end else if (m_in_pkt) begin
      e = '{h: 1'b0, t: in_tail, d: in_data, p: m_port};
      q.push_back(e);
      if (in_tail) m_in_pkt = 0;
    end else begin
      if (ERR) exp_err++;
    end
  endtask

  task automatic cycle();
    exp_t e;
    acc = 0;
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        acc = 1;
        model_push();
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_port", outport, prev_port);
      end
      if (out_valid) check("onehot", $countones(outport), 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("out_when_empty", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("out_head", out_head, e.h);
          check("out_tail", out_tail, e.t);
          check("out_data", out_data, e.d);
          check("outport", outport, e.p);
          last_port = outport;
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_port  = outport;
`ifdef ROUTE_ERR_EN
      if (route_err) got_err++;
`endif
    end else begin
      prev_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input logic h, input logic t, input logic [CW-1:0] dx,
                          input logic [CW-1:0] dy, input logic [DW-1:0] d);
    in_head = h; in_tail = t; dest_x = dx; dest_y = dy; in_data = d;
  endtask

  task automatic send(input logic h, input logic t, input logic [CW-1:0] dx,
                      input logic [CW-1:0] dy, input logic [DW-1:0] d);
    int n;
    set_flit(h, t, dx, dy, d);
    in_valid = 1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", acc, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      cycle();
      n++;
    end
    cycle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    cycle();
    rst = 0;
    q.delete();
    m_in_pkt = 0;
    m_drop = 0;
    prev_stall = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_head", out_head, 0);
    check("rst_out_tail", out_tail, 0);
    check("rst_out_data", out_data, 0);
    check("rst_outport", outport, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef ROUTE_ERR_EN
    check("rst_route_err", route_err, 0);
`endif
  endtask

  initial begin
    int nacc, rem, len, e0, o0;
    logic [CW-1:0] rx, ry;
    rst = 1; in_valid = 0; out_ready = 1;
    set_flit(0, 0, '0, '0, '0);
    cycle();
    do_reset();

    // single-flit packet east, latency of two edges
    set_flit(1, 1, 5, 1, 64'hA5A5_0001);
    in_valid = 1;
    check("t1_in_ready", in_ready, 1);
    cycle();
    in_valid = 0;
    check("t1_accepted", acc, 1);
    check("t1_not_yet", out_valid, 0);
    cycle();
    check("t1_valid", out_valid, 1);
    check("t1_port_east", outport, 5'b00010);
    check("t1_in_ready2", in_ready, 1);
    drain();

    // 4-flit packet north, then single-flit local
    send(1, 0, 3, 6, 64'h10);
    send(0, 0, 0, 0, 64'h11);
    send(0, 0, 0, 0, 64'h12);
    send(0, 1, 0, 0, 64'h13);
    send(1, 1, 3, 3, 64'h14);
    drain();
    check("t2_last_local", last_port, 5'b00001);

    // backpressure: 6 attempts with out_ready low, 5 fit
    out_ready = 0;
    nacc = 0;
    in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      set_flit(nacc == 0, 0, 0, 3, 64'h100 + nacc);
      cycle();
      if (acc) nacc++;
    end
    in_valid = 0;
    check("bp_accepted", nacc, 5);
    check("bp_in_ready_low", in_ready, 0);
    cycle();
    check("bp_still_low", in_ready, 0);
    check("bp_head_data", out_data, 64'h100);
    out_ready = 1;
    cycle();
    check("bp_ready_back", in_ready, 1);
    send(0, 1, 0, 0, 64'h1FF);
    drain();
    check("bp_last_west", last_port, 5'b00100);

    // reset mid-packet, orphan body dropped, next head routes south
    send(1, 0, 0, 3, 64'h200);
    do_reset();
    o0 = n_out;
    send(0, 0, 0, 0, 64'h201);
    drain();
    check("rst_orphan_dropped", n_out - o0, 0);
    send(1, 1, 3, 0, 64'h202);
    drain();
    check("rst_next_south", last_port, 5'b10000);

`ifdef ROUTE_ERR_EN
    e0 = got_err;
    o0 = n_out;
    send(1, 0, 9, 2, 64'h300);
    send(0, 0, 0, 0, 64'h301);
    send(0, 1, 0, 0, 64'h302);
    drain();
    check("err_pulses", got_err - e0, 1);
    check("err_no_output", n_out - o0, 0);
    send(1, 1, 6, 3, 64'h303);
    drain();
    check("err_next_east", last_port, 5'b00010);
    e0 = got_err;
    send(0, 1, 0, 0, 64'h304);
    drain();
    check("err_orphan_pulse", got_err - e0, 1);
`endif

    // random traffic
    rem = 0;
    in_valid = 0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc) begin
        if ($urandom_range(3) == 0) begin
          in_valid = 0;
        end else begin
          in_valid = 1;
          rx = CW'($urandom_range(9));
          ry = CW'($urandom_range(9));
          if ($urandom_range(15) == 0) rx = {CW{1'b1}};
          if (rem == 0) begin
            if ($urandom_range(9) == 0) begin
              set_flit(0, 1'($urandom_range(1)), rx, ry, {$urandom, $urandom});
            end else begin
              len = $urandom_range(1, 4);
              rem = len - 1;
              set_flit(1, len == 1, rx, ry, {$urandom, $urandom});
            end
          end else begin
            rem--;
            set_flit(0, rem == 0, rx, ry, {$urandom, $urandom});
          end
        end
      end
      out_ready = ($urandom_range(3) != 0);
      cycle();
    end
    drain();
`ifdef ROUTE_ERR_EN
    check("rand_err_count", got_err, exp_err);
`endif
    check("rand_outputs_seen", (n_out > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
